fp_div: RTL and testbench

Single-precision IEEE-754 floating-point divider. It is the responder on the processor's floating-point coprocessor handshake (`restart`/`start`/`done`), the same protocol the core's FP add and multiply units use. The core's execute FSM drives `N1`/`N2` from the register file, pulses `restart` in fetch, holds `start` in its FP-wait state, and advances when `done` rises. The quotient is computed by a multicycle restoring mantissa divider with truncation rounding.

---
 rtl/fp_div_if.sv | 21 ++
 rtl/fp_div.sv | 158 +++++++++++++++
 tb/tb_fp_div.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_if.sv
// Coprocessor handshake between the core's execute FSM and the FP divider:
// operands and control from the core, quotient and status back.
interface fp_div_if;
    logic        restart;
    logic        start;
    logic [31:0] N1;
    logic [31:0] N2;
    logic [31:0] q;
    logic        done;
    logic        dz;

    modport master (
        output restart, start, N1, N2,
        input  q, done, dz
    );

    modport slave (
        input  restart, start, N1, N2,
        output q, done, dz
    );
endinterface

// File: rtl/fp_div.sv
// Single-precision divider: unpack/classify, 25-step restoring mantissa
// division, then pack with truncation; specials bypass the divide loop.
module fp_div (
    input  logic     CLOCK_50,
    input  logic     reset,
    fp_div_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, PACK, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        a_r, b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        m2_r;
    logic [25:0]        rem_r;
    logic [24:0]        qt_r;
    logic [4:0]         cnt_r;
    logic               special_r;
    logic [31:0]        spec_q_r;
    logic               spec_dz_r;
    logic [31:0]        q_r;
    logic               done_r;
    logic               dz_r;

    // Operand fields and classification from the captured operands
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        z1, z2, inf1, inf2, nan1, nan2, sgn;
    logic        unpack_special;
    logic [31:0] unpack_q;
    logic        unpack_dz;

    always_comb begin
        e1   = a_r[30:23];
        e2   = b_r[30:23];
        f1   = a_r[22:0];
        f2   = b_r[22:0];
        sgn  = a_r[31] ^ b_r[31];
        z1   = (e1 == 8'h00);
        z2   = (e2 == 8'h00);
        inf1 = (e1 == 8'hFF) && (f1 == '0);
        inf2 = (e2 == 8'hFF) && (f2 == '0);
        nan1 = (e1 == 8'hFF) && (f1 != '0);
        nan2 = (e2 == 8'hFF) && (f2 != '0);

        unpack_special = 1'b1;
        unpack_dz      = 1'b0;
        unpack_q       = '0;
        // Order matters: NaN cases first, then x/0 ahead of 0/x and inf/x
        if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
            unpack_q = 32'h7FC0_0000;
        end else if (z2) begin
            unpack_q  = {sgn, 8'hFF, 23'd0};
            unpack_dz = 1'b1;
        end else if (z1 || inf2) begin
            unpack_q = {sgn, 31'd0};
        end else if (inf1) begin
            unpack_q = {sgn, 8'hFF, 23'd0};
        end else begin
            unpack_special = 1'b0;
        end
    end

    // One restoring iteration
    logic        ge;
    logic [25:0] rem_sub, rem_nxt;

    always_comb begin
        ge      = (rem_r >= {2'b00, m2_r});
        rem_sub = ge ? (rem_r - {2'b00, m2_r}) : rem_r;
        rem_nxt = rem_sub << 1;
    end

    // Normalise, truncate and range-check the quotient
    logic signed [9:0] exp_f;
    logic [22:0]       frac_f;
    logic [31:0]       pack_q;

    always_comb begin
        exp_f  = qt_r[24] ? exp_r : (exp_r - 10'sd1);
        frac_f = qt_r[24] ? qt_r[23:1] : qt_r[22:0];
        if (special_r)
            pack_q = spec_q_r;
        else if (exp_f >= 10'sd255)
            pack_q = {sign_r, 8'hFF, 23'd0};
        else if (exp_f <= 10'sd0)
            pack_q = {sign_r, 31'd0};
        else
            pack_q = {sign_r, exp_f[7:0], frac_f};
    end

    always_comb begin
        state_nxt = state;
        if (bus.restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = UNPACK;
                UNPACK:  state_nxt = unpack_special ? PACK : DIVIDE;
                DIVIDE:  if (cnt_r == 5'd24) state_nxt = PACK;
                PACK:    state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            q_r    <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            cnt_r  <= '0;
        end else begin
            state <= state_nxt;
            if (bus.restart) begin
                done_r <= 1'b0;
                dz_r   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            a_r <= bus.N1;
                            b_r <= bus.N2;
                        end
                    end
                    UNPACK: begin
                        sign_r    <= sgn;
                        special_r <= unpack_special;
                        spec_q_r  <= unpack_q;
                        spec_dz_r <= unpack_dz;
                        exp_r     <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
                        m2_r      <= {1'b1, f2};
                        rem_r     <= {3'b001, f1};
                        qt_r      <= '0;
                        cnt_r     <= '0;
                    end
                    DIVIDE: begin
                        rem_r <= rem_nxt;
                        qt_r  <= {qt_r[23:0], ge};
                        cnt_r <= cnt_r + 5'd1;
                    end
                    PACK: begin
                        q_r    <= pack_q;
                        dz_r   <= special_r & spec_dz_r;
                        done_r <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.done = done_r;
    assign bus.dz   = dz_r;
endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: reset, normal and special quotients, latency,
// hold in DONE, restart abort and mid-division reset.
module tb_fp_div;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    fp_div_if bus ();

    fp_div dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_cmp  = 0;
    int n_fail = 0;

    // Runs one restart->start request; lat counts edges after C until done reads 1
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rq, output logic rdz, output int lat);
        @(negedge CLOCK_50);
        bus.restart = 1'b1;
        bus.start   = 1'b0;
        @(negedge CLOCK_50);
        bus.restart = 1'b0;
        bus.start   = 1'b1;
        bus.N1      = a;
        bus.N2      = b;
        @(posedge CLOCK_50);
        #1;
        bus.N1 = ~a;
        bus.N2 = ~b;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        rq  = bus.q;
        rdz = bus.dz;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.restart = 1'b0;
        bus.start   = 1'b0;
        bus.N1      = '0;
        bus.N2      = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if (bus.q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_q: got %h want %h", bus.q, 32'h0);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        n_cmp++;
        if (bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dz: got %b want 0", bus.dz);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vq [7];
        logic        vdz [7];
        int          vlat [7];
        logic [31:0] rq;
        logic        rdz;
        int          lat;
        va = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'h7F000000,
               32'h00800000, 32'h3F800000, 32'h3FC00000};
        vb = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h00800000,
               32'h7F000000, 32'h3F800000, 32'hBF800000};
        vq = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000,
               32'h00000000, 32'h3F800000, 32'hBFC00000};
        vdz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vlat = '{27, 27, 27, 27, 27, 27, 27};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], rq, rdz, lat);
            n_cmp++;
            if (rq !== vq[i]) begin
                n_fail++;
                $display("FAIL normal_q[%0d] %h/%h: got %h want %h", i, va[i], vb[i], rq, vq[i]);
            end
            n_cmp++;
            if (rdz !== vdz[i]) begin
                n_fail++;
                $display("FAIL normal_dz[%0d]: got %b want %b", i, rdz, vdz[i]);
            end
            n_cmp++;
            if (lat != vlat[i]) begin
                n_fail++;
                $display("FAIL normal_latency[%0d]: got %0d want %0d", i, lat, vlat[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] vq [6];
        logic        vdz [6];
        logic [31:0] rq;
        logic        rdz;
        int          lat;
        va  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h40000000,
                32'h7FC12345, 32'h80000000};
        vb  = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000,
                32'h3F800000, 32'h3F800000};
        vq  = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                32'h7FC00000, 32'h80000000};
        vdz = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], rq, rdz, lat);
            n_cmp++;
            if (rq !== vq[i]) begin
                n_fail++;
                $display("FAIL special_q[%0d] %h/%h: got %h want %h", i, va[i], vb[i], rq, vq[i]);
            end
            n_cmp++;
            if (rdz !== vdz[i]) begin
                n_fail++;
                $display("FAIL special_dz[%0d]: got %b want %b", i, rdz, vdz[i]);
            end
            n_cmp++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL special_latency[%0d]: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_hold_and_restart();
        logic [31:0] rq;
        logic        rdz;
        int          lat;
        int          bad;
        do_op(32'h3F800000, 32'h00000000, rq, rdz, lat);
        bad = 0;
        repeat (6) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.done !== 1'b1 || bus.q !== 32'h7F800000 || bus.dz !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_in_done: %0d unstable cycles, want 0", bad);
        end
        @(negedge CLOCK_50);
        bus.restart = 1'b1;
        bus.start   = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b dz=%b want 0 0", bus.done, bus.dz);
        end
        n_cmp++;
        if (bus.q !== 32'h7F800000) begin
            n_fail++;
            $display("FAIL restart_q_hold: got %h want %h", bus.q, 32'h7F800000);
        end
        @(negedge CLOCK_50);
        bus.restart = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] rq;
        logic        rdz;
        int          lat;
        int          seen;
        @(negedge CLOCK_50);
        bus.restart = 1'b0;
        bus.start   = 1'b1;
        bus.N1      = 32'h40C00000;
        bus.N2      = 32'h40000000;
        @(posedge CLOCK_50);
        repeat (9) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.restart = 1'b1;
        bus.start   = 1'b0;
        @(negedge CLOCK_50);
        bus.restart = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.done !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done high %0d cycles, want 0", seen);
        end
        n_cmp++;
        if (bus.q !== 32'h7F800000) begin
            n_fail++;
            $display("FAIL abort_q_hold: got %h want %h", bus.q, 32'h7F800000);
        end
        do_op(32'h40C00000, 32'h40000000, rq, rdz, lat);
        n_cmp++;
        if (rq !== 32'h40400000 || lat != 27) begin
            n_fail++;
            $display("FAIL abort_rerun: got q=%h lat=%0d want q=40400000 lat=27", rq, lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge CLOCK_50);
        bus.restart = 1'b1;
        bus.start   = 1'b0;
        @(negedge CLOCK_50);
        bus.restart = 1'b0;
        bus.start   = 1'b1;
        bus.N1      = 32'h3F800000;
        bus.N2      = 32'h40400000;
        @(posedge CLOCK_50);
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if (bus.q !== 32'h0 || bus.done !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got q=%h done=%b dz=%b want 0 0 0", bus.q, bus.done, bus.dz);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
        seen = 0;
        repeat (35) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.done !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done high %0d cycles, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_hold_and_restart();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
